// File: rtl/camera_ctrl_rows_pkg.sv
// Shared types and sizing helpers for the row-sequencing camera controller.
// No logic; constants and pure functions only.
// No flow control.
package camera_pkg;

  // Controller phases, in frame order
  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    R_SETUP,
    R_CONV,
    R_HOLD
  } state_t;

  // Cycles a row slot adds on top of the ADC conversion: one setup, one hold
  localparam int SLOT_OVERHEAD = 2;

  // Cycles spent reading one row
  function automatic int slot_len(input int adc_cycles);
    return adc_cycles + SLOT_OVERHEAD;
  endfunction

  // Counter width able to index n values, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/camera_ctrl_rows_exp_time_ctrl.sv
// Exposure-time register with saturating +1/-1 adjust, gated by an enable.
// Latency: adjust visible one cycle after the request edge.
// No backpressure; requests seen while en=0 are dropped.
module exp_time_ctrl
  import camera_pkg::*;
#(
  parameter int EXP_W     = 5,
  parameter int EXP_MIN   = 2,
  parameter int EXP_MAX   = 30,
  parameter int EXP_RESET = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [EXP_W-1:0] ex_time
);

  // Saturating adjust; simultaneous inc and dec cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_time <= EXP_W'(EXP_RESET);
    end else if (en && inc && !dec && (ex_time < EXP_W'(EXP_MAX))) begin
      ex_time <= ex_time + EXP_W'(1);
    end else if (en && dec && !inc && (ex_time > EXP_W'(EXP_MIN))) begin
      ex_time <= ex_time - EXP_W'(1);
    end
  end

endmodule

// File: rtl/camera_ctrl_rows.sv
// Camera frame sequencer: erase, timed exposure, then per-row NRE/ADC readout.
// Latency: Init to Busy low = 1 + EX_time + ROWS*(ADC_CYCLES+2) cycles.
// No backpressure; Init and exposure adjust are ignored while Busy.
// Optional DARK_FRAME_EN adds a Dark input that turns EXPOSE into a dark frame.
module camera_ctrl_rows
  import camera_pkg::*;
#(
  parameter int EXP_W      = 5,
  parameter int EXP_MIN    = 2,
  parameter int EXP_MAX    = 30,
  parameter int EXP_RESET  = 2,
  parameter int ROWS       = 2,
  parameter int ADC_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Continuous,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
`ifdef DARK_FRAME_EN
  input  logic             Dark,
`endif
  output logic [ROWS-1:0]  NRE,
  output logic             ADC,
  output logic             Expose,
  output logic             Erase,
  output logic             Busy,
  output logic             Frame_done,
  output logic [EXP_W-1:0] EX_time
);

  localparam int SLOT = slot_len(ADC_CYCLES);
  localparam int RW   = cnt_w(ROWS);
  localparam int SW   = cnt_w(SLOT);

  state_t           state, state_nx;
  logic [EXP_W-1:0] timer;
  logic [RW-1:0]    row;
  logic [SW-1:0]    slot;
  logic             dark_q;
  logic             dark_in;
  logic [EXP_W-1:0] ex_time;
  logic             last_row;
  logic             timer_done;
  logic             conv_done;
  logic             idle;

`ifdef DARK_FRAME_EN
  assign dark_in = Dark;
`else
  assign dark_in = 1'b0;
`endif

  assign idle       = (state == IDLE);
  assign last_row   = (row == RW'(ROWS - 1));
  assign timer_done = (timer == EXP_W'(1));
  assign conv_done  = (slot == SW'(SLOT - 2));

  exp_time_ctrl #(
    .EXP_W    (EXP_W),
    .EXP_MIN  (EXP_MIN),
    .EXP_MAX  (EXP_MAX),
    .EXP_RESET(EXP_RESET)
  ) u_exp_time_ctrl (
    .clk    (Clk),
    .rst_n  (Reset),
    .en     (idle),
    .inc    (Exp_increase),
    .dec    (Exp_decrease),
    .ex_time(ex_time)
  );

  assign EX_time = ex_time;

  // Next-state logic for the frame sequence
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Init) state_nx = EXPOSE;
      ERASE:   state_nx = EXPOSE;
      EXPOSE:  if (timer_done) state_nx = R_SETUP;
      R_SETUP: state_nx = R_CONV;
      R_CONV:  if (conv_done) state_nx = R_HOLD;
      R_HOLD: begin
        if (!last_row)       state_nx = R_SETUP;
        else if (Continuous) state_nx = ERASE;
        else                 state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register plus exposure timer, row index and in-slot counter
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      timer  <= '0;
      row    <= '0;
      slot   <= '0;
      dark_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE, ERASE: begin
          // Exposure length and frame type are captured at frame start, so
          // an adjust landing on the same edge only affects later frames.
          if (state_nx == EXPOSE) begin
            timer  <= ex_time;
            row    <= '0;
            slot   <= '0;
            dark_q <= dark_in;
          end
        end
        EXPOSE: begin
          timer <= timer - EXP_W'(1);
          slot  <= '0;
        end
        R_SETUP: slot <= SW'(1);
        R_CONV:  slot <= slot + SW'(1);
        R_HOLD: begin
          slot <= '0;
          row  <= last_row ? '0 : row + RW'(1);
        end
        default: ;
      endcase
    end
  end

  // Decoded outputs; NRE selects the current row only during readout
  always_comb begin
    NRE = '1;
    if ((state == R_SETUP) || (state == R_CONV) || (state == R_HOLD)) begin
      for (int i = 0; i < ROWS; i++) begin
        if (row == RW'(i)) NRE[i] = 1'b0;
      end
    end
  end

  assign ADC        = (state == R_CONV);
  assign Expose     = (state == EXPOSE) && !dark_q;
  assign Erase      = idle || (state == ERASE) || ((state == EXPOSE) && dark_q);
  assign Busy       = !idle;
  assign Frame_done = (state == R_HOLD) && last_row;

endmodule

// File: tb/tb_camera_ctrl_rows.sv
// Self-checking bench: two controller instances (default and 4-row/2-cycle ADC).
// Expected per-cycle output vectors are queued at stimulus time and popped per cycle.
// Outputs sampled on the falling clock edge; inputs changed after sampling.
module tb_camera_ctrl_rows;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       init_a, cont_a, inc_a, dec_a;
  logic       init_b, cont_b, inc_b, dec_b;
  logic [1:0] nre_a;
  logic [3:0] nre_b;
  logic       adc_a, exp_a, era_a, busy_a, fd_a;
  logic       adc_b, exp_b, era_b, busy_b, fd_b;
  logic [4:0] ext_a, ext_b;
`ifdef DARK_FRAME_EN
  logic       dark_a, dark_b;
`endif

  camera_ctrl_rows dut_a (
    .Clk(clk), .Reset(rst_n), .Init(init_a), .Continuous(cont_a),
    .Exp_increase(inc_a), .Exp_decrease(dec_a),
`ifdef DARK_FRAME_EN
    .Dark(dark_a),
`endif
    .NRE(nre_a), .ADC(adc_a), .Expose(exp_a), .Erase(era_a),
    .Busy(busy_a), .Frame_done(fd_a), .EX_time(ext_a)
  );

  camera_ctrl_rows #(.ROWS(4), .ADC_CYCLES(2)) dut_b (
    .Clk(clk), .Reset(rst_n), .Init(init_b), .Continuous(cont_b),
    .Exp_increase(inc_b), .Exp_decrease(dec_b),
`ifdef DARK_FRAME_EN
    .Dark(dark_b),
`endif
    .NRE(nre_b), .ADC(adc_b), .Expose(exp_b), .Erase(era_b),
    .Busy(busy_b), .Frame_done(fd_b), .EX_time(ext_b)
  );

  // Vector layout: {nre[3:0], adc, expose, erase, busy, frame_done}
  typedef logic [8:0] vec_t;
  localparam vec_t IDLE_V = 9'b1111_00100;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t obs_a();
    return {2'b11, nre_a, adc_a, exp_a, era_a, busy_a, fd_a};
  endfunction

  function automatic vec_t obs_b();
    return {nre_b, adc_b, exp_b, era_b, busy_b, fd_b};
  endfunction

  // Reference frame model: optional erase cycle, exposure, then row slots
  task automatic push_frame(input int ext, input int rows, input int adc,
                            input bit from_erase, input bit dark);
    if (from_erase) exp_q.push_back({4'hF, 5'b00110});
    for (int i = 0; i < ext; i++)
      exp_q.push_back(dark ? {4'hF, 5'b00110} : {4'hF, 5'b01010});
    for (int r = 0; r < rows; r++) begin
      logic [3:0] n;
      logic       last;
      n    = ~(4'b0001 << r);
      last = (r == rows - 1);
      exp_q.push_back({n, 5'b00010});
      for (int c = 0; c < adc; c++) exp_q.push_back({n, 5'b10010});
      exp_q.push_back({n, 4'b0001, last});
    end
  endtask

  task automatic pulse_a(input bit inc, input bit dec, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); inc_a = inc; dec_a = dec;
      @(negedge clk); inc_a = 1'b0; dec_a = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_a = 0; cont_a = 0; inc_a = 0; dec_a = 0;
    init_b = 0; cont_b = 0; inc_b = 0; dec_b = 0;
`ifdef DARK_FRAME_EN
    dark_a = 0; dark_b = 0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ext_a !== 5'd2) begin errors++; $display("FAIL reset_ext_a got %0d exp 2", ext_a); end
    checks++;
    if (obs_b() !== IDLE_V) begin errors++; $display("FAIL reset_vec_b got %b exp %b", obs_b(), IDLE_V); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== IDLE_V || ext_a !== 5'd2) begin
        errors++;
        $display("FAIL idle_hold cyc %0d got %b/%0d exp %b/2", i, obs_a(), ext_a, IDLE_V);
      end
    end
  endtask

  task automatic test_single_frame();
    int idx = 0;
    @(negedge clk); init_a = 1'b1;
    push_frame(2, 2, 1, 0, 0);
    exp_q.push_back(IDLE_V);
    while (exp_q.size() > 0) begin
      vec_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs_a() !== e) begin errors++; $display("FAIL single_frame cyc %0d got %b exp %b", idx + 1, obs_a(), e); end
      init_a = 1'b0;
      idx++;
    end
  endtask

  task automatic test_saturation();
    int idx = 0;
    pulse_a(1, 0, 40);
    checks++;
    if (ext_a !== 5'd30) begin errors++; $display("FAIL sat_max got %0d exp 30", ext_a); end
    @(negedge clk); init_a = 1'b1;
    push_frame(30, 2, 1, 0, 0);
    exp_q.push_back(IDLE_V);
    while (exp_q.size() > 0) begin
      vec_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs_a() !== e) begin errors++; $display("FAIL long_frame cyc %0d got %b exp %b", idx + 1, obs_a(), e); end
      init_a = 1'b0;
      idx++;
    end
    pulse_a(0, 1, 40);
    checks++;
    if (ext_a !== 5'd2) begin errors++; $display("FAIL sat_min got %0d exp 2", ext_a); end
    pulse_a(1, 0, 1);
    checks++;
    if (ext_a !== 5'd3) begin errors++; $display("FAIL inc_one got %0d exp 3", ext_a); end
    pulse_a(1, 1, 1);
    checks++;
    if (ext_a !== 5'd3) begin errors++; $display("FAIL both_high got %0d exp 3", ext_a); end
    pulse_a(0, 1, 1);
    checks++;
    if (ext_a !== 5'd2) begin errors++; $display("FAIL dec_one got %0d exp 2", ext_a); end
  endtask

  task automatic test_busy();
    int idx = 0;
    @(negedge clk); init_a = 1'b1;
    push_frame(2, 2, 1, 0, 0);
    repeat (3) exp_q.push_back(IDLE_V);
    while (exp_q.size() > 0) begin
      vec_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs_a() !== e) begin errors++; $display("FAIL busy_frame cyc %0d got %b exp %b", idx + 1, obs_a(), e); end
      init_a = (idx == 3);
      inc_a  = (idx == 3);
      idx++;
    end
    checks++;
    if (ext_a !== 5'd2) begin errors++; $display("FAIL busy_adjust got %0d exp 2", ext_a); end
    // Init and increase on the same edge: frame uses 2, setting becomes 3
    idx = 0;
    @(negedge clk); init_a = 1'b1; inc_a = 1'b1;
    push_frame(2, 2, 1, 0, 0);
    exp_q.push_back(IDLE_V);
    while (exp_q.size() > 0) begin
      vec_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs_a() !== e) begin errors++; $display("FAIL init_adj_frame cyc %0d got %b exp %b", idx + 1, obs_a(), e); end
      init_a = 1'b0; inc_a = 1'b0;
      idx++;
    end
    checks++;
    if (ext_a !== 5'd3) begin errors++; $display("FAIL init_adj_ext got %0d exp 3", ext_a); end
    pulse_a(0, 1, 1);
  endtask

  task automatic test_continuous();
    int idx = 0;
    int last_fd = -1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); inc_b = 1'b1;
      @(negedge clk); inc_b = 1'b0;
    end
    checks++;
    if (ext_b !== 5'd5) begin errors++; $display("FAIL cont_ext got %0d exp 5", ext_b); end
    @(negedge clk); init_b = 1'b1; cont_b = 1'b1;
    push_frame(5, 4, 2, 0, 0);
    push_frame(5, 4, 2, 1, 0);
    push_frame(5, 4, 2, 1, 0);
    repeat (2) exp_q.push_back(IDLE_V);
    while (exp_q.size() > 0) begin
      vec_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs_b() !== e) begin errors++; $display("FAIL cont_frame cyc %0d got %b exp %b", idx + 1, obs_b(), e); end
      if (fd_b === 1'b1) begin
        if (last_fd >= 0) begin
          checks++;
          if (idx - last_fd != 22) begin errors++; $display("FAIL cont_period got %0d exp 22", idx - last_fd); end
        end
        last_fd = idx;
      end
      init_b = 1'b0;
      if (idx == 50) cont_b = 1'b0;
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    pulse_a(1, 0, 2);
    checks++;
    if (ext_a !== 5'd4) begin errors++; $display("FAIL pre_abort_ext got %0d exp 4", ext_a); end
    @(negedge clk); init_a = 1'b1;
    push_frame(4, 2, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      vec_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs_a() !== e) begin errors++; $display("FAIL abort_frame cyc %0d got %b exp %b", k, obs_a(), e); end
      init_a = 1'b0;
    end
    exp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (obs_a() !== IDLE_V) begin errors++; $display("FAIL abort_state got %b exp %b", obs_a(), IDLE_V); end
    checks++;
    if (ext_a !== 5'd2) begin errors++; $display("FAIL abort_ext got %0d exp 2", ext_a); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== IDLE_V) begin errors++; $display("FAIL abort_idle cyc %0d got %b exp %b", i, obs_a(), IDLE_V); end
    end
  endtask

`ifdef DARK_FRAME_EN
  task automatic test_dark();
    int idx = 0;
    @(negedge clk); init_a = 1'b1; dark_a = 1'b1;
    push_frame(2, 2, 1, 0, 1);
    exp_q.push_back(IDLE_V);
    while (exp_q.size() > 0) begin
      vec_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs_a() !== e) begin errors++; $display("FAIL dark_frame cyc %0d got %b exp %b", idx + 1, obs_a(), e); end
      init_a = 1'b0; dark_a = 1'b0;
      idx++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_saturation();
    test_busy();
    test_continuous();
    test_reset_mid();
`ifdef DARK_FRAME_EN
    test_dark();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
